mem_latency_responder: RTL and testbench

//  Response end of the per-request memory latency model. Accepts a request tagged with its core

---
 rtl/mem_latency_responder.sv | 98 +++++++++
 tb/tb_mem_latency_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_latency_responder.sv
// In-order delay FIFO: holds requests with a per-slot countdown and returns each segment tag once it matures.
// Optional MEM_LAT_STATS_EN adds back-pressure and peak-occupancy statistics outputs.
module mem_latency_responder #(
  parameter int unsigned SEG_W   = 5,
  parameter int unsigned DELAY_W = 10,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SEG_W-1:0]         req_seg,
  input  logic [DELAY_W-1:0]       req_delay,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [SEG_W-1:0]         resp_seg,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef MEM_LAT_STATS_EN
  ,
  output logic [31:0]              stat_bp_cycles,
  output logic [$clog2(DEPTH):0]   stat_max_occ
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [OW-1:0]      occ_q, occ_d;
  logic [DEPTH-1:0]   slot_vld;
  logic [SEG_W-1:0]   slot_seg [DEPTH];
  logic [DELAY_W-1:0] slot_cnt [DEPTH];
  logic               push, pop;

  assign req_ready  = (occ_q != OW'(DEPTH)) & ~stall;
  assign resp_valid = slot_vld[rd_ptr] & (slot_cnt[rd_ptr] == '0) & ~stall;
  assign resp_seg   = slot_vld[rd_ptr] ? slot_seg[rd_ptr] : '0;
  assign occupancy  = occ_q;
  assign push       = req_valid & req_ready;
  assign pop        = resp_valid & resp_ready;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)
      occ_d = occ_q + OW'(1);
    else if (pop && !push)
      occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ_q    <= '0;
      slot_vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_seg[i] <= '0;
        slot_cnt[i] <= '0;
      end
    end else begin
      if (!stall) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (slot_vld[i] && slot_cnt[i] != '0)
            slot_cnt[i] <= slot_cnt[i] - DELAY_W'(1);
        end
      end
      // The push slot is never occupied, so its load cannot collide with a decrement.
      if (push) begin
        slot_vld[wr_ptr] <= 1'b1;
        slot_seg[wr_ptr] <= req_seg;
        slot_cnt[wr_ptr] <= req_delay;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        slot_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + AW'(1);
      end
      occ_q <= occ_d;
    end
  end

`ifdef MEM_LAT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bp_cycles <= '0;
      stat_max_occ   <= '0;
    end else begin
      if (resp_valid && !resp_ready && stat_bp_cycles != '1)
        stat_bp_cycles <= stat_bp_cycles + 32'd1;
      // Track against the next occupancy so the peak includes the current cycle's value.
      if (occ_d > stat_max_occ)
        stat_max_occ <= occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_latency_responder.sv
// Bench for mem_latency_responder: directed scenarios plus random traffic against a
// queue-based model keyed on the number of unstalled cycles elapsed.
module tb_mem_latency_responder;

  logic       clk, reset, stall, req_valid, req_ready, resp_valid, resp_ready;
  logic [4:0] req_seg, resp_seg;
  logic [9:0] req_delay;
  logic [3:0] occupancy;
`ifdef MEM_LAT_STATS_EN
  logic [31:0] stat_bp_cycles;
  logic [3:0]  stat_max_occ;
`endif

  mem_latency_responder #(.SEG_W(5), .DELAY_W(10), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_seg(req_seg), .req_delay(req_delay),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_seg(resp_seg),
    .occupancy(occupancy)
`ifdef MEM_LAT_STATS_EN
    , .stat_bp_cycles(stat_bp_cycles), .stat_max_occ(stat_max_occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      seg;
    longint unsigned mature_at;
  } ent_t;

  ent_t            q[$];
  longint unsigned act_cycles = 0;
  longint unsigned m_bp       = 0;
  int unsigned     m_maxocc   = 0;
  int unsigned     n_checks   = 0;
  int unsigned     n_pass     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic rv, input logic [4:0] sg, input logic [9:0] d,
                      input logic rr, input logic st, input logic rst);
    logic       e_rdy, e_rv;
    logic [4:0] e_seg;
    int unsigned e_occ;
    req_valid = rv; req_seg = sg; req_delay = d;
    resp_ready = rr; stall = st; reset = rst;
    e_occ = q.size();
    e_rdy = (e_occ != 8) && !st;
    e_rv  = !st && (e_occ > 0) && (act_cycles >= q[0].mature_at);
    e_seg = (e_occ > 0) ? q[0].seg : 5'd0;
    @(negedge clk);
    if (!rst) begin
      check("occupancy",  64'(occupancy),  64'(e_occ));
      check("req_ready",  64'(req_ready),  64'(e_rdy));
      check("resp_valid", 64'(resp_valid), 64'(e_rv));
      check("resp_seg",   64'(resp_seg),   64'(e_seg));
`ifdef MEM_LAT_STATS_EN
      check("stat_bp_cycles", 64'(stat_bp_cycles), 64'(m_bp));
      check("stat_max_occ",   64'(stat_max_occ),   64'(m_maxocc));
`endif
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_bp = 0;
      m_maxocc = 0;
    end else begin
      if (e_rv && !rr && m_bp != 64'hFFFF_FFFF) m_bp++;
      if (e_rv && rr) void'(q.pop_front());
      if (e_rdy && rv) q.push_back('{seg: sg, mature_at: act_cycles + 1 + 64'(d)});
      if (!st) act_cycles++;
      if (q.size() > m_maxocc) m_maxocc = q.size();
    end
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic rr);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 5'd0, 10'd0, rr, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; req_valid = 1'b0; req_seg = '0; req_delay = '0; resp_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 5'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);

    // Single request seg=3 d=5
    step(1'b1, 5'd3, 10'd5, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);

    // Long head followed by an immediate one: strict ordering
    step(1'b1, 5'd1, 10'd10, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd2, 10'd0,  1'b1, 1'b0, 1'b0);
    idle(14, 1'b1);

    // Fill to capacity, then hold a ninth request until the first pop
    for (int unsigned i = 0; i < 8; i++) step(1'b1, 5'(i + 8), 10'd50, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 56; i++) step(1'b1, 5'd31, 10'd2, 1'b1, 1'b0, 1'b0);
    idle(20, 1'b1);

    // Stall three cycles mid-countdown
    step(1'b1, 5'd7, 10'd4, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 5'd9, 10'd0, 1'b1, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Matured head held by back-pressure for five cycles
    step(1'b1, 5'd21, 10'd0, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    idle(3, 1'b1);

    // Reset with three outstanding, then a fresh d=0 request
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 5'(i + 4), 10'd6, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 10'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd17, 10'd0, 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1);

    // Random traffic phases: {valid %, ready %, stall %, max delay, reset per-mille}
    begin
      int unsigned pv[4]   = '{60, 90, 30, 80};
      int unsigned pr[4]   = '{80, 30, 90, 60};
      int unsigned ps[4]   = '{10, 20, 5, 0};
      int unsigned pd[4]   = '{8, 60, 3, 1023};
      int unsigned prst[4] = '{5, 3, 10, 2};
      for (int unsigned p = 0; p < 4; p++) begin
        for (int unsigned i = 0; i < 1500; i++) begin
          step($urandom_range(0, 99) < pv[p],
               5'($urandom_range(0, 31)),
               10'($urandom_range(0, pd[p])),
               $urandom_range(0, 99) < pr[p],
               $urandom_range(0, 99) < ps[p],
               $urandom_range(0, 999) < prst[p]);
        end
        idle(40, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
